// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard interface: datapath-side stage information in,
// forwarding selects, stall/flush controls and event counters out.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              RegWriteM;
    logic              RegWriteW;
    logic [REG_AW-1:0] RDM;
    logic [REG_AW-1:0] RdW;
    logic [REG_AW-1:0] RS1E;
    logic [REG_AW-1:0] RS2E;
    logic [REG_AW-1:0] RS1D;
    logic [REG_AW-1:0] RS2D;
    logic [REG_AW-1:0] RDE;
    logic              LoadE;
    logic              PCSrcE;
    logic              cnt_clr;
    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              stall_busy;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    // Datapath side
    modport master (
        output RegWriteM, RegWriteW, RDM, RdW, RS1E, RS2E, RS1D, RS2D, RDE,
               LoadE, PCSrcE, cnt_clr,
        input  ForwardA_E, ForwardB_E, StallF, StallD, FlushD, FlushE,
               stall_busy, stall_count, flush_count
    );

    // Hazard controller side
    modport slave (
        input  RegWriteM, RegWriteW, RDM, RdW, RS1E, RS2E, RS1D, RS2D, RDE,
               LoadE, PCSrcE, cnt_clr,
        output ForwardA_E, ForwardB_E, StallF, StallD, FlushD, FlushE,
               stall_busy, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: E-stage forwarding selects,
// multi-cycle load-use stall sequencing, taken-branch flush and
// saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hif
);
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0] REM_INIT = 4'(LOAD_LAT - 1);

    state_t           state;
    logic [3:0]       rem;
    logic             lw_haz;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic             flush_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // M-stage result wins over W-stage; x0 is never forwarded
    function automatic logic [1:0] fwd_sel(
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w,
        input logic [REG_AW-1:0] rs
    );
        if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Forwarding, load-use detection and stall/flush controls; forced low in reset
    always_comb begin
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        lw_haz  = 1'b0;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (reset) begin
            fwd_a  = fwd_sel(hif.RegWriteM, hif.RDM, hif.RegWriteW, hif.RdW, hif.RS1E);
            fwd_b  = fwd_sel(hif.RegWriteM, hif.RDM, hif.RegWriteW, hif.RdW, hif.RS2E);
            lw_haz = hif.LoadE && (hif.RDE != '0) &&
                     ((hif.RDE == hif.RS1D) || (hif.RDE == hif.RS2D));
            if (hif.PCSrcE) begin
                // taken branch overrides any load-use stall, including one in progress
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if ((state == STALL) || lw_haz) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Stall sequencer: the IDLE detection cycle counts as the first stall cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rem   <= '0;
        end else if (hif.PCSrcE) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lw_haz && (LOAD_LAT > 1)) begin
                        state <= STALL;
                        rem   <= REM_INIT;
                    end
                end
                STALL: begin
                    if (rem == 4'd1) begin
                        state <= IDLE;
                        rem   <= '0;
                    end else begin
                        rem <= rem - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rem   <= '0;
                end
            endcase
        end
    end

    // Saturating event counters; clear wins over increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (hif.cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (hif.PCSrcE && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hif.ForwardA_E  = fwd_a;
    assign hif.ForwardB_E  = fwd_b;
    assign hif.StallF      = stall_f;
    assign hif.StallD      = stall_d;
    assign hif.FlushD      = flush_d;
    assign hif.FlushE      = flush_e;
    assign hif.stall_busy  = (state == STALL);
    assign hif.stall_count = stall_cnt;
    assign hif.flush_count = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: dut0 uses LOAD_LAT=3/CNT_W=4,
// dut1 uses LOAD_LAT=1/CNT_W=16.
module tb_hazard_ctrl;
    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  h0 ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) h1 ();

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .hif   (h0.slave)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .hif   (h1.slave)
    );

    // {StallF, StallD, FlushD, FlushE, stall_busy}
    logic [4:0] st0;
    logic [4:0] st1;
    logic [3:0] fw0;
    assign st0 = {h0.StallF, h0.StallD, h0.FlushD, h0.FlushE, h0.stall_busy};
    assign st1 = {h1.StallF, h1.StallD, h1.FlushD, h1.FlushE, h1.stall_busy};
    assign fw0 = {h0.ForwardA_E, h0.ForwardB_E};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        h0.RegWriteM = 1'b0; h0.RegWriteW = 1'b0;
        h0.RDM = '0; h0.RdW = '0; h0.RS1E = '0; h0.RS2E = '0;
        h0.RS1D = '0; h0.RS2D = '0; h0.RDE = '0;
        h0.LoadE = 1'b0; h0.PCSrcE = 1'b0; h0.cnt_clr = 1'b0;
        h1.RegWriteM = 1'b0; h1.RegWriteW = 1'b0;
        h1.RDM = '0; h1.RdW = '0; h1.RS1E = '0; h1.RS2E = '0;
        h1.RS1D = '0; h1.RS2D = '0; h1.RDE = '0;
        h1.LoadE = 1'b0; h1.PCSrcE = 1'b0; h1.cnt_clr = 1'b0;
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        h0.cnt_clr = 1'b1;
        h1.cnt_clr = 1'b1;
        cyc();
        h0.cnt_clr = 1'b0;
        h1.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        h0.RegWriteM = 1'b1; h0.RDM = 5'd5; h0.RS1E = 5'd5; h0.RS2E = 5'd5;
        h0.LoadE = 1'b1; h0.RDE = 5'd7; h0.RS1D = 5'd7; h0.PCSrcE = 1'b1;
        #2;
        nvec++;
        if (fw0 !== 4'b0000) begin nerr++; $display("FAIL rst_fwd got %b want %b", fw0, 4'b0000); end
        nvec++;
        if (st0 !== 5'b00000) begin nerr++; $display("FAIL rst_status got %b want %b", st0, 5'b00000); end
        cyc();
        nvec++;
        if ({h0.stall_count, h0.flush_count} !== 8'h00) begin
            nerr++; $display("FAIL rst_counters got %h want %h", {h0.stall_count, h0.flush_count}, 8'h00);
        end
        idle_inputs();
        reset = 1'b1;
        #1;
        nvec++;
        if (st0 !== 5'b00000) begin nerr++; $display("FAIL rst_release got %b want %b", st0, 5'b00000); end
    endtask

    task automatic test_forwarding();
        cyc();
        idle_inputs();
        h0.RegWriteM = 1'b1; h0.RDM = 5'd5; h0.RegWriteW = 1'b1; h0.RdW = 5'd5;
        h0.RS1E = 5'd5; h0.RS2E = 5'd0;
        #1;
        nvec++;
        if (fw0 !== 4'b1000) begin nerr++; $display("FAIL fwd_m_prio got %b want %b", fw0, 4'b1000); end
        h0.RegWriteM = 1'b0;
        #1;
        nvec++;
        if (fw0 !== 4'b0100) begin nerr++; $display("FAIL fwd_w_only got %b want %b", fw0, 4'b0100); end
        h0.RegWriteM = 1'b1; h0.RDM = 5'd0; h0.RS1E = 5'd0; h0.RdW = 5'd0;
        #1;
        nvec++;
        if (fw0 !== 4'b0000) begin nerr++; $display("FAIL fwd_x0 got %b want %b", fw0, 4'b0000); end
        h0.RDM = 5'd3; h0.RdW = 5'd9; h0.RS1E = 5'd9; h0.RS2E = 5'd3;
        #1;
        nvec++;
        if (fw0 !== 4'b0110) begin nerr++; $display("FAIL fwd_split got %b want %b", fw0, 4'b0110); end
        h0.RegWriteW = 1'b0;
        #1;
        nvec++;
        if (fw0 !== 4'b0010) begin nerr++; $display("FAIL fwd_w_off got %b want %b", fw0, 4'b0010); end
        nvec++;
        if (st0 !== 5'b00000) begin nerr++; $display("FAIL fwd_no_stall got %b want %b", st0, 5'b00000); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        clear_counters();
        h0.LoadE = 1'b1; h0.RDE = 5'd7; h0.RS2D = 5'd7;
        #1;
        nvec++;
        if (st0 !== 5'b11010) begin nerr++; $display("FAIL lu_c1 got %b want %b", st0, 5'b11010); end
        cyc();
        h0.LoadE = 1'b0;
        #1;
        nvec++;
        if (st0 !== 5'b11011) begin nerr++; $display("FAIL lu_c2 got %b want %b", st0, 5'b11011); end
        cyc();
        nvec++;
        if (st0 !== 5'b11011) begin nerr++; $display("FAIL lu_c3 got %b want %b", st0, 5'b11011); end
        cyc();
        nvec++;
        if (st0 !== 5'b00000) begin nerr++; $display("FAIL lu_c4 got %b want %b", st0, 5'b00000); end
        nvec++;
        if (h0.stall_count !== 4'd3) begin nerr++; $display("FAIL lu_count got %0d want %0d", h0.stall_count, 3); end
    endtask

    task automatic test_branch_in_stall();
        clear_counters();
        h0.LoadE = 1'b1; h0.RDE = 5'd7; h0.RS1D = 5'd7;
        cyc();
        h0.LoadE = 1'b0; h0.PCSrcE = 1'b1;
        #1;
        nvec++;
        if (st0 !== 5'b00111) begin nerr++; $display("FAIL br_stall_c2 got %b want %b", st0, 5'b00111); end
        cyc();
        h0.PCSrcE = 1'b0;
        #1;
        nvec++;
        if (st0 !== 5'b00000) begin nerr++; $display("FAIL br_stall_c3 got %b want %b", st0, 5'b00000); end
        nvec++;
        if ({h0.stall_count, h0.flush_count} !== 8'h11) begin
            nerr++; $display("FAIL br_counts got %h want %h", {h0.stall_count, h0.flush_count}, 8'h11);
        end
    endtask

    task automatic test_simultaneous();
        clear_counters();
        h0.LoadE = 1'b1; h0.RDE = 5'd4; h0.RS1D = 5'd4; h0.PCSrcE = 1'b1;
        #1;
        nvec++;
        if (st0 !== 5'b00110) begin nerr++; $display("FAIL simul_c1 got %b want %b", st0, 5'b00110); end
        cyc();
        idle_inputs();
        #1;
        nvec++;
        if (st0 !== 5'b00000) begin nerr++; $display("FAIL simul_c2 got %b want %b", st0, 5'b00000); end
        nvec++;
        if ({h0.stall_count, h0.flush_count} !== 8'h01) begin
            nerr++; $display("FAIL simul_counts got %h want %h", {h0.stall_count, h0.flush_count}, 8'h01);
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        h0.LoadE = 1'b1; h0.RDE = 5'd2; h0.RS2D = 5'd2;
        for (int i = 0; i < 20; i++) begin
            cyc();
        end
        nvec++;
        if (h0.stall_count !== 4'd15) begin nerr++; $display("FAIL sat_count got %0d want %0d", h0.stall_count, 15); end
        nvec++;
        if (h0.StallD !== 1'b1) begin nerr++; $display("FAIL sat_stalld got %b want %b", h0.StallD, 1'b1); end
        h0.cnt_clr = 1'b1;
        cyc();
        h0.cnt_clr = 1'b0;
        nvec++;
        if (h0.stall_count !== 4'd0) begin nerr++; $display("FAIL sat_clr got %0d want %0d", h0.stall_count, 0); end
        cyc();
        nvec++;
        if (h0.stall_count !== 4'd1) begin nerr++; $display("FAIL sat_restart got %0d want %0d", h0.stall_count, 1); end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cyc();
        end
    endtask

    task automatic test_reset_mid_stall();
        h0.LoadE = 1'b1; h0.RDE = 5'd6; h0.RS1D = 5'd6;
        h0.RegWriteM = 1'b1; h0.RDM = 5'd6; h0.RS1E = 5'd6;
        cyc();
        nvec++;
        if (st0 !== 5'b11011) begin nerr++; $display("FAIL mid_pre got %b want %b", st0, 5'b11011); end
        reset = 1'b0;
        #1;
        nvec++;
        if ({st0, fw0} !== 9'b0) begin nerr++; $display("FAIL mid_rst got %b want %b", {st0, fw0}, 9'b0); end
        nvec++;
        if (h0.stall_count !== 4'd0) begin nerr++; $display("FAIL mid_rst_cnt got %0d want %0d", h0.stall_count, 0); end
        idle_inputs();
        cyc();
        reset = 1'b1;
        cyc();
        nvec++;
        if (st0 !== 5'b00000) begin nerr++; $display("FAIL mid_after got %b want %b", st0, 5'b00000); end
    endtask

    task automatic test_single_cycle_lat();
        clear_counters();
        h1.LoadE = 1'b1; h1.RDE = 5'd8; h1.RS1D = 5'd8;
        #1;
        nvec++;
        if (st1 !== 5'b11010) begin nerr++; $display("FAIL lat1_c1 got %b want %b", st1, 5'b11010); end
        cyc();
        nvec++;
        if (st1 !== 5'b11010) begin nerr++; $display("FAIL lat1_c2 got %b want %b", st1, 5'b11010); end
        cyc();
        h1.LoadE = 1'b0;
        #1;
        nvec++;
        if (st1 !== 5'b00000) begin nerr++; $display("FAIL lat1_c3 got %b want %b", st1, 5'b00000); end
        nvec++;
        if (h1.stall_count !== 16'd2) begin nerr++; $display("FAIL lat1_count got %0d want %0d", h1.stall_count, 2); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_in_stall();
        test_simultaneous();
        test_saturation();
        test_reset_mid_stall();
        test_single_cycle_lat();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
